ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Single-port arbiter placed between the video RAM and its two requesters, the CPU data port and the VGA pixel fetch. It grants at most one RAM access per clock and translates screen-relative VGA addresses into the RAM screen window. It returns read data to the requester that issued the read. VGA has priority, but a starvation counter guarantees the CPU a slot after a bounded wait.

## Interface
Parameters:
- ADDR_W, 15, RAM word-address width (2**15 registers).
- DATA_W, 16, RAM word width.
- SCREEN_OFFSET, 16384, RAM base address of the screen window.
- STARVE_LIMIT, 4, consecutive denied CPU cycles before the CPU is forced to win.

Ports:
- CLK_50  in  1  sole clock; everything is sampled on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with its fields until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  absolute RAM address.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  the CPU access is issued to RAM this cycle.
- cpu_rvalid  out  1  CPU read data is valid this cycle.
- cpu_rdata  out  DATA_W  CPU read data.
- vga_req  in  1  VGA fetch request; read only.
- vga_addr  in  ADDR_W-1  screen-relative word address.
- vga_gnt  out  1  the VGA fetch is issued this cycle.
- vga_rvalid  out  1  VGA read data is valid this cycle.
- vga_rdata  out  DATA_W  VGA read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after the read address is presented.

## Operation
- Grant rule, decided combinationally each cycle from the requests and the starvation count:
  - If the starvation count equals STARVE_LIMIT and cpu_req is high, the CPU wins.
  - Otherwise, if vga_req is high, VGA wins.
  - Otherwise, if cpu_req is high, the CPU wins.
  - Otherwise, no grant.
- gnt is asserted in the same cycle the access drives the RAM port. The requester may change its request fields in the next cycle.
- RAM port, CPU winner: ram_addr = cpu_addr, ram_we = cpu_we, ram_wdata = cpu_wdata.
- RAM port, VGA winner: ram_addr = SCREEN_OFFSET + vga_addr (ADDR_W wide, modulo 2**ADDR_W), ram_we = 0.
- RAM port, no winner: ram_addr = 0, ram_we = 0, ram_wdata = 0.
- Read-owner register (owner_t) captures the winner of each read: CPU on a CPU read grant, VGA on a VGA grant, NONE on a CPU write or no grant.
- Next cycle: the rvalid output of the recorded owner pulses for one cycle. Both rdata outputs are wired to ram_rdata; each is meaningful only while its rvalid is high.
- Starvation count (0..STARVE_LIMIT, saturating):
  - Increments on each cycle with cpu_req high and cpu_gnt low.
  - Clears on cpu_gnt or when cpu_req is low.
- Mode FSM:
  - NORMAL: the count is below STARVE_LIMIT.
  - BOOST: the count equals STARVE_LIMIT.
  - BOOST returns to NORMAL the cycle after cpu_gnt.
- Simultaneous requests in NORMAL: VGA is granted; the CPU is not granted and its count advances.
- A CPU write and a VGA read to the same address never occur in the same cycle. Each access sees the RAM state left by earlier grants.

## Timing
- Reset (RESET_N low at an edge):
  - Owner becomes NONE, the count becomes 0, the FSM goes to NORMAL.
  - cpu_rvalid and vga_rvalid are 0 in the cycle after reset.
  - A read issued in the reset cycle is dropped: no rvalid.
- gnt and ram_* are combinational. While reset is low they are forced to 0 / no grant.
- Read latency: gnt in cycle N gives rvalid in cycle N+1. Back-to-back grants give back-to-back rvalid pulses.
- Worst-case CPU wait under continuous VGA requests: STARVE_LIMIT cycles, so the grant lands in cycle STARVE_LIMIT after the request is raised.

## Structure
- Package ram_arb_pkg: owner_t enum {OWN_NONE, OWN_CPU, OWN_VGA}, mode_t enum {NORMAL, BOOST}, and the default constants for ADDR_W, DATA_W and SCREEN_OFFSET, shared with ram and vga.
- One sub-module, starve_counter: the saturating count plus the NORMAL/BOOST FSM, parameterised by STARVE_LIMIT, with cpu_boost as its output.

## Test plan
- CPU-only write: addr 0x0010, data 0xBEEF. Expect cpu_gnt in the same cycle, ram_we=1, no rvalid. A following CPU read of 0x0010 returns cpu_rvalid with 0xBEEF one cycle later.
- VGA-only read, vga_addr 0x0005: expect ram_addr=0x4005, vga_rvalid on the next cycle, cpu_rvalid stays 0.
- Continuous vga_req plus cpu_req raised at cycle 0 (STARVE_LIMIT=4):
  - vga_gnt in cycles 0–3, cpu_gnt in cycle 4, vga_gnt resumes in cycle 5.
  - The count reads 1,2,3,4 and then 0.
- Interleaved VGA read in cycle N and CPU read in cycle N+1: vga_rvalid in N+1, cpu_rvalid in N+2, each with the matching RAM word.
- vga_addr=0x3FFF maps to ram_addr=0x7FFF. A SCREEN_OFFSET override of 0x7FFF with vga_addr=1 wraps to ram_addr=0x0000.
- RESET_N low in the cycle of a granted VGA read: no vga_rvalid follows, the count is 0, and the next cpu_req is granted immediately.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default geometry for the video RAM, its arbiter and the VGA fetch.
package ram_arb_pkg;

  localparam int unsigned RAM_ADDR_W        = 15;
  localparam int unsigned RAM_DATA_W        = 16;
  localparam int unsigned RAM_SCREEN_OFFSET = 16384;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VGA
  } owner_t;

  typedef enum logic {
    NORMAL,
    BOOST
  } mode_t;

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive denied CPU cycles and raises cpu_boost once the limit is reached,
// so the arbiter can force a CPU slot against continuous VGA traffic.
module starve_counter
  import ram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cpu_req,
  input  logic i_cpu_gnt,
  output logic o_cpu_boost
);

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  mode_t            r_mode;
  mode_t            w_mode_next;

  always_comb begin
    w_count_next = r_count;
    if (!i_cpu_req || i_cpu_gnt) begin
      w_count_next = '0;
    end else if (r_count != LP_LIMIT) begin
      w_count_next = r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mode <= NORMAL;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  // Mode tracks the registered count: BOOST exactly while the count sits at the limit.
  always_comb begin
    w_mode_next = r_mode;
    case (r_mode)
      NORMAL:  if (w_count_next == LP_LIMIT) w_mode_next = BOOST;
      BOOST:   if (w_count_next != LP_LIMIT) w_mode_next = NORMAL;
      default: w_mode_next = NORMAL;
    endcase
  end

  always_comb begin
    o_cpu_boost = (r_mode == BOOST);
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port video RAM arbiter: VGA has priority, the CPU is guaranteed a slot after
// STARVE_LIMIT denied cycles; read data is steered back to whichever side issued the read.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = RAM_ADDR_W,
  parameter int unsigned DATA_W        = RAM_DATA_W,
  parameter int unsigned SCREEN_OFFSET = RAM_SCREEN_OFFSET,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic              CLK_50,
  input  logic              RESET_N,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-2:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LP_OFFSET = ADDR_W'(SCREEN_OFFSET);

  logic              w_boost;
  logic              w_cpu_win;
  logic              w_vga_win;
  logic [ADDR_W-1:0] w_vga_ram_addr;
  owner_t            r_owner;
  owner_t            w_owner_next;

  starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .i_clk      (CLK_50),
    .i_rst_n    (RESET_N),
    .i_cpu_req  (cpu_req),
    .i_cpu_gnt  (w_cpu_win),
    .o_cpu_boost(w_boost)
  );

  // Screen window translation wraps modulo 2**ADDR_W.
  assign w_vga_ram_addr = LP_OFFSET + ADDR_W'(vga_addr);

  always_comb begin
    w_cpu_win = RESET_N && cpu_req && (w_boost || !vga_req);
    w_vga_win = RESET_N && vga_req && !w_cpu_win;
  end

  assign cpu_gnt = w_cpu_win;
  assign vga_gnt = w_vga_win;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (w_cpu_win) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end else if (w_vga_win) begin
      ram_addr  = w_vga_ram_addr;
    end
  end

  always_comb begin
    w_owner_next = OWN_NONE;
    if (w_cpu_win && !cpu_we) begin
      w_owner_next = OWN_CPU;
    end else if (w_vga_win) begin
      w_owner_next = OWN_VGA;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  assign cpu_rvalid = (r_owner == OWN_CPU);
  assign vga_rvalid = (r_owner == OWN_VGA);
  assign cpu_rdata  = ram_rdata;
  assign vga_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: grants and RAM port checked per cycle,
// returned read data checked by a queue-based monitor against a behavioural RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        vga_req;
  logic [13:0] vga_addr;
  logic        vga_gnt, vga_rvalid;
  logic [15:0] vga_rdata;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  logic [13:0] d2_vga_addr;
  logic        d2_cpu_gnt, d2_cpu_rvalid, d2_vga_gnt, d2_vga_rvalid, d2_ram_we;
  logic [15:0] d2_cpu_rdata, d2_vga_rdata, d2_ram_wdata;
  logic [14:0] d2_ram_addr;

  logic [15:0] mem [0:32767];
  logic [15:0] cpu_q [$];
  logic [15:0] vga_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ram_port_arbiter u_dut (
    .CLK_50(clk), .RESET_N(RESET_N),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_port_arbiter #(.SCREEN_OFFSET(32'h7FFF)) u_dut2 (
    .CLK_50(clk), .RESET_N(RESET_N),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(15'h0000), .cpu_wdata(16'h0000),
    .cpu_gnt(d2_cpu_gnt), .cpu_rvalid(d2_cpu_rvalid), .cpu_rdata(d2_cpu_rdata),
    .vga_req(vga_req), .vga_addr(d2_vga_addr), .vga_gnt(d2_vga_gnt),
    .vga_rvalid(d2_vga_rvalid), .vga_rdata(d2_vga_rdata),
    .ram_addr(d2_ram_addr), .ram_we(d2_ram_we), .ram_wdata(d2_ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous RAM, one-cycle read latency; screen words preloaded while in reset.
  always @(posedge clk) begin
    if (!RESET_N) begin
      for (int i = 0; i < 16; i++) mem[15'h4000 + 15'(i)] <= 16'hA000 + 16'(i);
      mem[15'h7FFF] <= 16'h7777;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  function automatic void chk(input string tag, input string what,
                              input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got 0x%0h, required 0x%0h", tag, what, got, exp);
    end
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) chk("mon", "cpu_rvalid_unexpected", 32'(cpu_rdata), 32'hFFFF_FFFF);
        else chk("mon", "cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
      end
      if (vga_rvalid) begin
        if (vga_q.size() == 0) chk("mon", "vga_rvalid_unexpected", 32'(vga_rdata), 32'hFFFF_FFFF);
        else chk("mon", "vga_rdata", 32'(vga_rdata), 32'(vga_q.pop_front()));
      end
    end
  endtask

  task automatic step(input logic rn, input logic cr, input logic cw,
                      input logic [14:0] ca, input logic [15:0] cd,
                      input logic vr, input logic [13:0] va,
                      input logic ecg, input logic evg, input logic [14:0] ea,
                      input logic ewe, input logic [15:0] ewd, input logic [15:0] erd,
                      input int ecnt, input string tag);
    @(negedge clk);
    RESET_N   = rn;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
    vga_req   = vr;
    vga_addr  = va;
    #1;
    chk(tag, "cpu_gnt", 32'(cpu_gnt), 32'(ecg));
    chk(tag, "vga_gnt", 32'(vga_gnt), 32'(evg));
    chk(tag, "ram_addr", 32'(ram_addr), 32'(ea));
    chk(tag, "ram_we", 32'(ram_we), 32'(ewe));
    if (ewe) chk(tag, "ram_wdata", 32'(ram_wdata), 32'(ewd));
    if (ecnt >= 0) chk(tag, "starve_count", 32'(u_dut.u_starve.r_count), 32'(ecnt));
    if (ecg && !cw) cpu_q.push_back(erd);
    if (evg) vga_q.push_back(erd);
  endtask

  task automatic idle(input string tag);
    step(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 14'h0,
         1'b0, 1'b0, 15'h0, 1'b0, 16'h0, 16'h0, 0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0; d2_vga_addr = 14'h0001;
    fork
      monitor();
    join_none

    step(1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 14'h0, 1'b0, 1'b0, 15'h0, 1'b0, 16'h0, 16'h0, -1, "rst0");
    step(1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 14'h0, 1'b0, 1'b0, 15'h0, 1'b0, 16'h0, 16'h0, 0, "rst1");

    step(1'b1, 1'b1, 1'b1, 15'h0010, 16'hBEEF, 1'b0, 14'h0, 1'b1, 1'b0, 15'h0010, 1'b1, 16'hBEEF, 16'h0, 0, "cpu_wr");
    step(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b0, 14'h0, 1'b1, 1'b0, 15'h0010, 1'b0, 16'h0, 16'hBEEF, 0, "cpu_rd");
    idle("idle_a");

    step(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 14'h0005, 1'b0, 1'b1, 15'h4005, 1'b0, 16'h0, 16'hA005, 0, "vga_rd");
    idle("idle_b");

    // Continuous VGA with a pending CPU read: CPU forced through in cycle 4.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, 14'(i), 1'b0, 1'b1, 15'h4000 + 15'(i),
           1'b0, 16'h0, 16'hA000 + 16'(i), i, "starve");
    step(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, 14'h0004, 1'b1, 1'b0, 15'h0010, 1'b0, 16'h0, 16'hBEEF, 4, "boost");
    step(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 14'h0004, 1'b0, 1'b1, 15'h4004, 1'b0, 16'h0, 16'hA004, 0, "resume");
    idle("idle_c");

    step(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 14'h0007, 1'b0, 1'b1, 15'h4007, 1'b0, 16'h0, 16'hA007, 0, "ilv_vga");
    step(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b0, 14'h0, 1'b1, 1'b0, 15'h0010, 1'b0, 16'h0, 16'hBEEF, 0, "ilv_cpu");
    idle("idle_d");

    step(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 14'h3FFF, 1'b0, 1'b1, 15'h7FFF, 1'b0, 16'h0, 16'h7777, 0, "top_edge");
    chk("wrap", "d2_vga_gnt", 32'(d2_vga_gnt), 32'h1);
    chk("wrap", "d2_ram_addr", 32'(d2_ram_addr), 32'h0000);
    idle("idle_e");

    step(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, 14'h0001, 1'b0, 1'b1, 15'h4001, 1'b0, 16'h0, 16'hA001, 0, "pre_rst0");
    step(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, 14'h0002, 1'b0, 1'b1, 15'h4002, 1'b0, 16'h0, 16'hA002, 1, "pre_rst1");
    step(1'b0, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, 14'h0003, 1'b0, 1'b0, 15'h0000, 1'b0, 16'h0, 16'h0, 2, "in_rst");
    step(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b0, 14'h0, 1'b1, 1'b0, 15'h0010, 1'b0, 16'h0, 16'hBEEF, 0, "post_rst");
    idle("idle_f");
    idle("idle_g");
    idle("idle_h");

    chk("end", "cpu_q_left", 32'(cpu_q.size()), 32'h0);
    chk("end", "vga_q_left", 32'(vga_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
